// File: rtl/mm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mm_sequencer
// Purpose  : Run controller for one systolic C = A x B pass. Handshakes with
//            the host (start/busy/done), gates the array's feed counters,
//            counts tile feeds, steers the per-row result streams into N1
//            output banks with computed write addresses, and raises sticky
//            protocol / drain-timeout error flags.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            start                    - host start (accepted only in IDLE)
//            busy, done               - RUN|DRAIN status, one-cycle done pulse
//            err[1:0]                 - bit0 bad/excess valid, bit1 timeout
//            enable_row_count_A       - feed-counter enable to the array
//            pixel_cntr_A             - feed position from the array
//            valid_D, D               - per-lane result stream from the array
//            wr_en_D, wr_addr_D,
//            wr_data_D                - per-bank write port, 1-cycle latency
// Revision : 1.0 - initial release
// ============================================================================
module mm_sequencer #(
    parameter int D_W_ACC   = 16,
    parameter int N1        = 4,
    parameter int N2        = 4,
    parameter int M         = 8,
    parameter int DRAIN_MAX = 256
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    output logic                                       busy,
    output logic                                       done,
    output logic [1:0]                                 err,
    output logic                                       enable_row_count_A,
    input  logic [$clog2(M)-1:0]                       pixel_cntr_A,
    input  logic [N1-1:0]                              valid_D,
    input  logic [N1-1:0][D_W_ACC-1:0]                 D,
    output logic [N1-1:0]                              wr_en_D,
    output logic [N1-1:0][$clog2(M*M/N1)-1:0]          wr_addr_D,
    output logic [N1-1:0][D_W_ACC-1:0]                 wr_data_D
);

    localparam int c_T   = (M * M) / (N1 * N2);   // tiles per pass
    localparam int c_R   = M * M;                 // total results
    localparam int c_TPR = M / N2;                // tiles per tile-row
    localparam int c_PW  = $clog2(M);
    localparam int c_AW  = $clog2(M * M / N1);
    localparam int c_KW  = (N2 > 1) ? $clog2(N2) : 1;
    localparam int c_TW  = $clog2(c_T + 1);
    localparam int c_RW  = $clog2(c_R + 1);
    localparam int c_DW  = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;

    logic [c_TW-1:0]                r_feed_cnt;
    logic [c_RW-1:0]                r_res_cnt;
    logic [c_DW-1:0]                r_drain_cnt;
    logic [1:0]                     r_err;
    logic [c_KW-1:0]                r_beat [N1];
    logic [c_TW-1:0]                r_tile [N1];
    logic [N1-1:0]                  r_wr_en;
    logic [N1-1:0][c_AW-1:0]        r_wr_addr;
    logic [N1-1:0][D_W_ACC-1:0]     r_wr_data;

    logic                           w_active;
    logic                           w_start_acc;
    logic                           w_feed;
    logic                           w_timeout;
    logic [N1-1:0]                  w_acc;
    logic [N1-1:0]                  w_bad;
    logic [c_RW-1:0]                w_res_nxt;
    logic [c_AW-1:0]                w_addr [N1];

    assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_feed      = (r_state == S_RUN) && (pixel_cntr_A == c_PW'(M - 1));

    // Lane acceptance, result accounting and bank address generation.
    always_comb begin
        w_acc     = '0;
        w_bad     = '0;
        w_res_nxt = r_res_cnt;
        for (int i = 0; i < N1; i++) begin
            w_acc[i]  = valid_D[i] && w_active && (r_tile[i] < c_TW'(c_T));
            w_bad[i]  = valid_D[i] && !w_acc[i];
            w_res_nxt = w_res_nxt + c_RW'(w_acc[i]);
            // First beat of a tile is its right-most column.
            w_addr[i] = c_AW'((int'(r_tile[i]) / c_TPR) * M
                            + (int'(r_tile[i]) % c_TPR) * N2
                            + (N2 - 1 - int'(r_beat[i])));
        end
    end

    // Next-state logic. Completion uses the count including this cycle's beats.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_feed && (r_feed_cnt == c_TW'(c_T - 1))) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_res_nxt >= c_RW'(c_R)) begin
                    w_state_nxt = S_DONE;
                end else if (r_drain_cnt == c_DW'(DRAIN_MAX - 1)) begin
                    w_state_nxt = S_DONE;
                    w_timeout   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, error flags and the registered bank write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_feed_cnt  <= '0;
            r_res_cnt   <= '0;
            r_drain_cnt <= '0;
            r_err       <= '0;
            r_wr_en     <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            for (int i = 0; i < N1; i++) begin
                r_beat[i] <= '0;
                r_tile[i] <= '0;
            end
        end else begin
            r_err <= (w_start_acc ? 2'b00 : r_err) | {w_timeout, |w_bad};

            if (w_start_acc) begin
                r_feed_cnt <= '0;
                r_res_cnt  <= '0;
            end else begin
                if (w_feed) begin
                    r_feed_cnt <= r_feed_cnt + 1'b1;
                end
                r_res_cnt <= w_res_nxt;
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end

            r_wr_en <= w_acc;
            for (int i = 0; i < N1; i++) begin
                if (w_start_acc) begin
                    r_beat[i] <= '0;
                    r_tile[i] <= '0;
                end else if (w_acc[i]) begin
                    r_wr_addr[i] <= w_addr[i];
                    r_wr_data[i] <= D[i];
                    if (r_beat[i] == c_KW'(N2 - 1)) begin
                        r_beat[i] <= '0;
                        r_tile[i] <= r_tile[i] + 1'b1;
                    end else begin
                        r_beat[i] <= r_beat[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign busy               = w_active;
    assign done               = (r_state == S_DONE);
    assign enable_row_count_A = (r_state == S_RUN);
    assign err                = r_err;
    assign wr_en_D            = r_wr_en;
    assign wr_addr_D          = r_wr_addr;
    assign wr_data_D          = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_sequencer
// Purpose  : Scoreboard bench for mm_sequencer (N1=N2=4, M=8, DRAIN_MAX=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic [1:0]         err;
    logic               enable_row_count_A;
    logic [2:0]         pixel_cntr_A;
    logic [3:0]         valid_D;
    logic [3:0][15:0]   D;
    logic [3:0]         wr_en_D;
    logic [3:0][3:0]    wr_addr_D;
    logic [3:0][15:0]   wr_data_D;

    typedef struct packed {
        logic [1:0]  lane;
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks      = 0;
    int errors      = 0;
    int quad_cycles = 0;

    // Bank address of beat n (global beat index within a lane), worked by hand.
    logic [3:0] addr_tab [16] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd7, 4'd6, 4'd5, 4'd4,
                                  4'd11, 4'd10, 4'd9, 4'd8, 4'd15, 4'd14, 4'd13, 4'd12};

    mm_sequencer #(
        .D_W_ACC   (16),
        .N1        (4),
        .N2        (4),
        .M         (8),
        .DRAIN_MAX (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .enable_row_count_A (enable_row_count_A),
        .pixel_cntr_A       (pixel_cntr_A),
        .valid_D            (valid_D),
        .D                  (D),
        .wr_en_D            (wr_en_D),
        .wr_addr_D          (wr_addr_D),
        .wr_data_D          (wr_data_D)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_en_D[i]) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: lane %0d addr %0h data %0h, no write expected",
                                 i, wr_addr_D[i], wr_data_D[i]);
                    end else begin
                        mon_e = sb_q.pop_front();
                        if (mon_e.lane != 2'(i) || mon_e.addr != wr_addr_D[i] || mon_e.data != wr_data_D[i]) begin
                            errors++;
                            $display("FAIL write_match: got lane %0d addr %0h data %0d, expected lane %0d addr %0h data %0d",
                                     i, wr_addr_D[i], wr_data_D[i], mon_e.lane, mon_e.addr, mon_e.data);
                        end
                    end
                end
            end
            if (wr_en_D == 4'hF) quad_cycles++;
        end
    end

    task automatic step_idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
        end
    endtask

    // mode 0 nominal staggered lanes (+ start during RUN), 1 all lanes together,
    // 2 excess beat on lane 1, 3 only 60 results, 5 same as 3 with rst in DRAIN.
    task automatic run(input int mode, input int rst_at);
        int first [4];
        int nb [4];
        int n [4];
        int pix, en_cycles, drain_start, done_cyc, done_cnt, quad0, stray;
        logic en_s;
        for (int i = 0; i < 4; i++) begin
            first[i] = (mode == 0) ? 10 + 4 * i : (mode == 1 || mode == 2) ? 20 : 10;
            nb[i]    = 16;
            n[i]     = 0;
        end
        if (mode == 2) begin first[1] = 19; nb[1] = 17; end
        if (mode == 3 || mode == 5) nb[3] = 12;
        pix = 0; en_cycles = 0; drain_start = -1; done_cyc = -1; done_cnt = 0;
        quad0 = quad_cycles;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_enable", {31'd0, enable_row_count_A}, 32'd1);
        chk("start_clears_err", {30'd0, err}, 32'd0);

        for (int cyc = 0; cyc < 150; cyc++) begin
            pixel_cntr_A = 3'(pix);
            valid_D = 4'd0;
            for (int i = 0; i < 4; i++) begin
                if (cyc >= first[i] && cyc < first[i] + nb[i]) begin
                    valid_D[i] = 1'b1;
                    D[i] = 16'(100 * i + n[i]);
                    if (n[i] < 16) sb_q.push_back('{lane: 2'(i), addr: addr_tab[n[i]], data: D[i]});
                    n[i]++;
                end
            end
            start = (mode == 0 && cyc == 5);
            rst   = (rst_at >= 0 && drain_start >= 0 && cyc == drain_start + rst_at);
            en_s  = enable_row_count_A;
            @(posedge clk); #1;
            if (en_s) begin en_cycles++; pix = (pix + 1) % 8; end
            if (busy && !enable_row_count_A && drain_start < 0) drain_start = cyc + 1;
            if (done) begin done_cnt++; done_cyc = cyc + 1; end
            if (rst) break;
            if (done_cyc >= 0 && cyc + 1 > done_cyc + 2) break;
        end
        rst = 1'b0; start = 1'b0; valid_D = 4'd0;

        if (rst_at >= 0) begin
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_enable", {31'd0, enable_row_count_A}, 32'd0);
            stray = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (wr_en_D != 4'd0 || busy) stray++;
            end
            chk("rst_no_writes", 32'(stray), 32'd0);
            chk("rst_err", {30'd0, err}, 32'd0);
            chk("rst_sb_empty", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end else begin
            chk("done_once", 32'(done_cnt), 32'd1);
            chk("enable_cycles", 32'(en_cycles), 32'd32);
            chk("idle_after_done", {31'd0, busy}, 32'd0);
            chk("sb_empty", 32'(sb_q.size()), 32'd0);
            case (mode)
                0: chk("err_nominal", {30'd0, err}, 32'd0);
                1: begin
                    chk("err_all_lanes", {30'd0, err}, 32'd0);
                    chk("quad_write_cycles", 32'(quad_cycles - quad0), 32'd16);
                end
                2: chk("err_excess", {30'd0, err}, 32'd1);
                3: begin
                    chk("err_timeout", {30'd0, err}, 32'd2);
                    chk("timeout_latency", 32'(done_cyc - drain_start), 32'd16);
                end
                default: ;
            endcase
        end
        step_idle(2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid_D = 4'd0; D = '0; pixel_cntr_A = 3'd0;
        step_idle(3);
        chk("rst_busy0", {31'd0, busy}, 32'd0);
        chk("rst_done0", {31'd0, done}, 32'd0);
        chk("rst_err0", {30'd0, err}, 32'd0);
        chk("rst_en0", {31'd0, enable_row_count_A}, 32'd0);
        chk("rst_wren0", {28'd0, wr_en_D}, 32'd0);
        chk("rst_addr0", {16'd0, wr_addr_D}, 32'd0);
        chk("rst_data0", wr_data_D[1:0], 32'd0);
        rst = 1'b0;
        step_idle(2);

        valid_D = 4'b0001; D[0] = 16'd55;
        @(posedge clk); #1;
        valid_D = 4'd0;
        chk("idle_valid_err", {30'd0, err}, 32'd1);
        chk("idle_valid_nowrite", {28'd0, wr_en_D}, 32'd0);
        step_idle(2);

        run(0, -1);
        run(1, -1);
        run(2, -1);
        run(3, -1);
        run(5, 2);
        run(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mm_sequencer.md
Name: mm_sequencer

Overview:
- Top-level run controller for one systolic matrix-multiply pass: C = A x B, where A and B are M x M and the array is N1 x N2 processing elements.
- Handles start/busy/done with the host and gates enable_row_count_A into the array's control counters.
- Counts tile feeds, collects the per-row result streams valid_D/D into N1 output banks with computed write addresses, and flags protocol errors and drain timeouts.
- Instantiated beside systolic, between it and the output BRAM banks.

Parameters:
- D_W_ACC, 16, result data width.
- N1, 4, array rows; also the number of result lanes and output banks.
- N2, 4, array columns; results per lane per tile.
- M, 8, matrix dimension. M must be divisible by N1 and by N2.
- DRAIN_MAX, 256, cycles allowed in DRAIN before a timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  host start request, sampled only in IDLE.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse on entering DONE.
- err  out  2  sticky flags: bit0 = unexpected/excess valid, bit1 = drain timeout. Cleared by rst or by an accepted start.
- enable_row_count_A  out  1  drives the array's feed counters.
- pixel_cntr_A  in  clog2(M)  from the array.
- valid_D  in  N1  per-lane result valid from the array.
- D  in  N1 x D_W_ACC  per-lane result data.
- wr_en_D  out  N1  per-bank write enable.
- wr_addr_D  out  N1 x clog2(M*M/N1)  per-bank write address.
- wr_data_D  out  N1 x D_W_ACC  per-bank write data.

Behaviour:
- Definitions: T = M*M/(N1*N2) tiles; total results R = M*M.
- Reset: FSM goes to IDLE. busy, done, err, enable_row_count_A, wr_en_D, wr_addr_D, wr_data_D and all counters are 0. Reset mid-run aborts with no further writes.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start=1. This clears err, the tile-feed counter, the result counter and the per-lane counters.
- RUN: enable_row_count_A=1. A tile feed is counted on each cycle where enable_row_count_A=1 and pixel_cntr_A==M-1.
- RUN -> DRAIN on the cycle the T-th feed is counted. enable_row_count_A is 0 from the next cycle onward.
- DRAIN: a cycle counter increments every cycle.
- DRAIN -> DONE when the result counter reaches R, checked after the current cycle's writes are included.
- DRAIN -> DONE with err[1] set when the drain counter reaches DRAIN_MAX - 1 and the result counter is still below R.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- start while busy is ignored.
- Per-lane collection, for each lane i:
  - Beat counter k runs 0..N2-1; lane tile counter t runs 0..T-1.
  - Tile coordinates: tr = t / (M/N2), tc = t mod (M/N2).
  - Beat order within a tile: the first beat is column N2-1, the last is column 0. So col = tc*N2 + (N2-1-k), and the write address is tr*M + col.
  - On valid_D[i]=1 in RUN or DRAIN with t < T: register wr_en_D[i]=1, wr_data_D[i]=D[i] and the address. Output latency is 1 cycle from valid.
  - After the beat: k increments; when k wraps from N2-1 to 0, t increments.
- Lanes are independent. Simultaneous valids on several lanes all write in the same cycle, and the result counter adds popcount of the accepted valids.
- Error cases for err[0] (the beat is not written):
  - valid_D[i] in IDLE or DONE.
  - valid_D[i] on lane i after its t has reached T.
- Result counter width is clog2(R+1) and it never wraps.
- wr_en_D is 0 on any cycle without an accepted valid. wr_addr_D and wr_data_D hold their last values.

Test Plan (defaults: N1=N2=4, M=8, T=4, R=64):
- Reset, then idle: all outputs 0. A valid_D=4'b0001 pulse in IDLE -> err=2'b01, no wr_en_D.
- Nominal run: start pulse, model pixel_cntr_A wrapping 4 times, then drive 4 beats per lane per tile with data value = 100*lane + beat index.
  - enable_row_count_A drops the cycle after the 4th wrap.
  - Lane 0, tile 0 beats go to addresses 3, 2, 1, 0.
  - Lane 2, tile 3 beats go to addresses 15, 14, 13, 12.
  - done pulses once after the 64th write; err=0.
- All four lanes valid in the same cycle: 4 writes in that cycle and the result counter advances by 4.
- Excess beat: a 17th beat on lane 1 -> err[0]=1, no write; the other lanes complete normally.
- Timeout with DRAIN_MAX=16: drive only 60 results -> DONE 16 cycles after entering DRAIN, err[1]=1, done pulses.
- Robustness:
  - rst asserted mid-DRAIN -> IDLE next cycle, no writes afterward.
  - start during RUN is ignored.
  - A new start after done clears err and completes a clean run.
